mipi_rx_raw_depacker_multi: RTL and testbench
=============================================

# mipi_rx_raw_depacker_multi

Parametrised successor to the fixed 4-lane RAW10 depacker. Sits after the CSI-2 packet decoder and takes the long-packet payload bytes, 1, 2 or 4 lanes wide. It unpacks RAW8, RAW10 or RAW12, selected per packet, into groups of four MSB-aligned pixels, with a per-packet pixel counter and packet-end and short-payload flags. Its output feeds the ISP pixel pipeline.

## Interface
- NUM_LANES, 4, payload bytes per beat; legal values 1, 2, 4.
- PIXEL_WIDTH, 12, output bits per pixel; must be ≥12.
- clk_i  in  1  pixel-side byte clock.
- rst_n_i  in  1  asynchronous, active-low reset. One clock only.
- data_valid_i  in  1  payload beat valid. High continuously for the whole packet; low between packets.
- data_i  in  8*NUM_LANES  payload beat. Byte 0 (earliest) is data_i[7:0].
- mode_i  in  2  format select: 00 RAW8, 01 RAW10, 10 RAW12, 11 reserved.
- pixel_valid_o  out  1  pixels_o holds a new 4-pixel group.
- pixels_o  out  4*PIXEL_WIDTH  four pixels. Pixel 0 (earliest) is in the top slice. Each pixel is MSB-aligned with its LSBs zero-filled.
- pixel_count_o  out  16  pixels emitted in the current packet.
- packet_end_o  out  1  one-cycle pulse when a packet ends.
- short_error_o  out  1  one-cycle pulse when a packet ends with a partial group, or when mode 11 was sampled.

## Operation
- **Packet start:** the first data_valid_i=1 cycle after a 0 cycle, or after reset.
  - mode_i is sampled at packet start into the active mode register.
  - mode_i changes mid-packet are ignored.
- **Group size G:** RAW8 = 4 bytes, RAW10 = 5 bytes, RAW12 = 6 bytes. Every group yields exactly 4 pixels.
- **Byte accumulator:** 16-byte buffer with a byte count cnt.
  - Each valid beat appends NUM_LANES bytes.
  - If cnt + NUM_LANES ≥ G, the oldest G bytes form a group and are removed. At most one group is removed per beat; the maximum residual is G-1 + NUM_LANES ≤ 9.
- **Unpack rules** (Bn = n-th byte of the group):
  - RAW8: pixel k = Bk.
  - RAW10: pixel k = {Bk, B4[2k+1:2k]}.
  - RAW12: p0 = {B0, B2[3:0]}, p1 = {B1, B2[7:4]}, p2 = {B3, B5[3:0]}, p3 = {B4, B5[7:4]}.
  - Each pixel is left-shifted to PIXEL_WIDTH bits.
- **Mode 11 (reserved):**
  - Bytes are consumed but no groups are emitted.
  - short_error_o pulses at packet end.
- **Packet end:** the first data_valid_i=0 cycle after a 1 cycle.
  - Residual bytes are discarded and cnt is cleared.
  - packet_end_o pulses.
  - short_error_o also pulses if cnt ≠ 0 or the mode was reserved.
- **pixel_count_o:**
  - Next value = (packet start ? 0 : current) + (group emitted ? 4 : 0).
  - Updates on the same edge as pixel_valid_o.
  - Wraps modulo 2^16.
  - Holds its value after packet end until the next packet start.
- **While data_valid_i = 0:** pixel_valid_o = 0 and pixels_o = 0.

## Timing
- **Reset values:** every output and internal register is 0, asserted asynchronously. Deassertion is synchronous to clk_i via the existing reset synchroniser.
- **Reset mid-packet:** accumulator, count and mode are cleared, with no packet_end_o. The next valid beat is a packet start.
- **Latency:** a group completed by the beat at edge N appears with pixel_valid_o=1 after edge N+1. All outputs are registered.
- **Steady-state output rate, 4 lanes:**
  - RAW8: every beat.
  - RAW10: 4 of every 5 beats, with the first output on beat 2.
  - RAW12: 2 of every 3 beats.
- **Steady-state output rate, 1 lane:** one group every G beats.
- **Packet end timing:** packet_end_o and short_error_o are high in the cycle after the first low data_valid_i cycle.
- **Back-to-back packets:** a single low cycle between packets is legal. The end pulse of one packet and the first output of the next packet never overlap, because outputs need at least one beat.
- No backpressure: the downstream must accept every pixel_valid_o cycle.

## Test plan
1. **RAW10 single group (4 lanes, PIXEL_WIDTH=12):** one packet of 5 beats; the first group's bytes are AA 55 FF 00 E4.
   - Required: the first group gives pixels 0xAA0, 0x554, 0xFF8, 0x00C.
   - Required: pixel_valid_o is high after beats 2–5, and pixel_count_o ends at 16.
2. **RAW12 (4 lanes):** bytes 12 34 65 AB CD EF.
   - Required: pixels 0x125, 0x346, 0xABF, 0xCDE.
   - Required: pixel_valid_o is high after beat 2 only.
3. **RAW8 (NUM_LANES=1):** 8 beats 01..08.
   - Required: groups {0x010,0x020,0x030,0x040} after beat 4 and {0x050,…,0x080} after beat 8.
   - Required: packet_end_o pulses and short_error_o stays 0.
4. **Short payload:** RAW10, 4 lanes, 3 beats (12 bytes = 2 groups + 2 residual bytes).
   - Required: 2 groups emitted, pixel_count_o = 8.
   - Required: packet_end_o and short_error_o both pulse.
5. **Mode change and back-to-back packets:** mode_i toggles mid-packet; then a single idle cycle, and a new packet with mode RAW8.
   - Required: the first packet decodes with its sampled mode throughout.
   - Required: the second packet decodes as RAW8, and pixel_count_o restarts at 4.
6. **Reset mid-packet:** assert rst_n_i low during beat 3 of a RAW10 packet.
   - Required: all outputs are 0 immediately, with no packet_end_o.
   - Required: a new packet decodes correctly from its first byte.

Source files
------------

// File: rtl/mipi_rx_raw_depacker_multi.sv
// CSI-2 long-packet payload depacker for RAW8/RAW10/RAW12.
// Payload bytes arrive NUM_LANES per beat. They are gathered into groups of
// 4, 5 or 6 bytes, and each group is unpacked into four MSB-aligned pixels.
// The output stage is a single register: a group completed by a beat is
// presented in the cycle after that beat.
module mipi_rx_raw_depacker_multi #(
  parameter int NUM_LANES   = 4,
  parameter int PIXEL_WIDTH = 12
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       data_valid_i,
  input  logic [8*NUM_LANES-1:0]     data_i,
  input  logic [1:0]                 mode_i,
  output logic                       pixel_valid_o,
  output logic [4*PIXEL_WIDTH-1:0]   pixels_o,
  output logic [15:0]                pixel_count_o,
  output logic                       packet_end_o,
  output logic                       short_error_o
);

  typedef enum logic [1:0] {
    MODE_RAW8  = 2'b00,
    MODE_RAW10 = 2'b01,
    MODE_RAW12 = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  // Residual is at most 9 bytes, plus one beat of at most 4 bytes, so 16
  // entries never overflow.
  logic [7:0]  buf_q   [16];
  logic [4:0]  cnt_q;
  mode_e       mode_q;
  logic        valid_d_q;

  logic        pkt_start;
  logic        pkt_end;
  mode_e       eff_mode;
  logic [4:0]  eff_cnt;
  logic [4:0]  total;
  logic [2:0]  grp;
  logic        emit;
  logic [4:0]  cnt_next;
  logic [4:0]  src;
  logic [7:0]  merged  [16];
  logic [7:0]  shifted [16];
  logic [11:0] p12     [4];
  logic [4*PIXEL_WIDTH-1:0] pix_word;

  // Append the incoming beat, decide whether a group is complete and unpack it.
  always_comb begin
    pkt_start = data_valid_i & ~valid_d_q;
    pkt_end   = ~data_valid_i & valid_d_q;
    // At packet start the new mode and an empty accumulator apply to this beat.
    eff_mode  = pkt_start ? mode_e'(mode_i) : mode_q;
    eff_cnt   = pkt_start ? 5'd0 : cnt_q;

    case (eff_mode)
      MODE_RAW8:  grp = 3'd4;
      MODE_RAW10: grp = 3'd5;
      MODE_RAW12: grp = 3'd6;
      default:    grp = 3'd4;
    endcase

    merged = buf_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      merged[4'(eff_cnt + 5'(i))] = data_i[8*i +: 8];
    end

    total = eff_cnt + 5'(NUM_LANES);
    emit  = data_valid_i && (eff_mode != MODE_RSVD) && (total >= {2'b00, grp});

    src = '0;
    for (int i = 0; i < 16; i++) begin
      src = 5'(i) + {2'b00, grp};
      shifted[4'(i)] = (src < 5'd16) ? merged[src[3:0]] : 8'h00;
    end

    // Reserved mode swallows bytes without accumulating them.
    if (emit)
      cnt_next = total - {2'b00, grp};
    else if (eff_mode == MODE_RSVD)
      cnt_next = 5'd0;
    else
      cnt_next = total;

    for (int k = 0; k < 4; k++) p12[k] = 12'h000;
    case (eff_mode)
      MODE_RAW8: begin
        p12[0] = {merged[0], 4'h0};
        p12[1] = {merged[1], 4'h0};
        p12[2] = {merged[2], 4'h0};
        p12[3] = {merged[3], 4'h0};
      end
      MODE_RAW10: begin
        p12[0] = {merged[0], merged[4][1:0], 2'b00};
        p12[1] = {merged[1], merged[4][3:2], 2'b00};
        p12[2] = {merged[2], merged[4][5:4], 2'b00};
        p12[3] = {merged[3], merged[4][7:6], 2'b00};
      end
      MODE_RAW12: begin
        p12[0] = {merged[0], merged[2][3:0]};
        p12[1] = {merged[1], merged[2][7:4]};
        p12[2] = {merged[3], merged[5][3:0]};
        p12[3] = {merged[4], merged[5][7:4]};
      end
      default: ;
    endcase

    // Pixel 0 occupies the top slice; widen then shift to MSB-align.
    pix_word = '0;
    for (int k = 0; k < 4; k++) begin
      pix_word[(3-k)*PIXEL_WIDTH +: PIXEL_WIDTH] =
        PIXEL_WIDTH'(p12[k]) << (PIXEL_WIDTH - 12);
    end
  end

  // Accumulator, packet tracking and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 16; i++) buf_q[i] <= 8'h00;
      cnt_q         <= '0;
      mode_q        <= MODE_RAW8;
      valid_d_q     <= 1'b0;
      pixel_valid_o <= 1'b0;
      pixels_o      <= '0;
      pixel_count_o <= '0;
      packet_end_o  <= 1'b0;
      short_error_o <= 1'b0;
    end else begin
      valid_d_q <= data_valid_i;
      if (pkt_start) mode_q <= mode_e'(mode_i);

      if (data_valid_i) begin
        cnt_q <= cnt_next;
        buf_q <= emit ? shifted : merged;
        pixel_count_o <= (pkt_start ? 16'd0 : pixel_count_o) + (emit ? 16'd4 : 16'd0);
      end else begin
        // Residual bytes of an ended packet are dropped.
        cnt_q <= '0;
      end

      pixel_valid_o <= emit;
      pixels_o      <= emit ? pix_word : '0;
      packet_end_o  <= pkt_end;
      short_error_o <= pkt_end && ((cnt_q != 5'd0) || (mode_q == MODE_RSVD));
    end
  end

endmodule

// File: tb/tb_mipi_rx_raw_depacker_multi.sv
// Directed bench: a 4-lane and a 1-lane depacker share clock and reset.
module tb_mipi_rx_raw_depacker_multi;

  logic        clk_i = 1'b0;
  logic        rst_n_i;

  logic        v4;
  logic [31:0] d4;
  logic [1:0]  m4;
  logic        pv4, pe4, se4;
  logic [47:0] px4;
  logic [15:0] pc4;

  logic        v1;
  logic [7:0]  d1;
  logic [1:0]  m1;
  logic        pv1, pe1, se1;
  logic [47:0] px1;
  logic [15:0] pc1;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  mipi_rx_raw_depacker_multi #(.NUM_LANES(4), .PIXEL_WIDTH(12)) u4 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .data_valid_i(v4), .data_i(d4), .mode_i(m4),
    .pixel_valid_o(pv4), .pixels_o(px4), .pixel_count_o(pc4),
    .packet_end_o(pe4), .short_error_o(se4));

  mipi_rx_raw_depacker_multi #(.NUM_LANES(1), .PIXEL_WIDTH(12)) u1 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .data_valid_i(v1), .data_i(d1), .mode_i(m1),
    .pixel_valid_o(pv1), .pixels_o(px1), .pixel_count_o(pc1),
    .packet_end_o(pe1), .short_error_o(se1));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_n_i = 1'b0;
    v4 = 1'b0; d4 = '0; m4 = 2'b00;
    v1 = 1'b0; d1 = '0; m1 = 2'b00;
    tick();
    check("rst_valid", pv4, 1'b0);
    check("rst_pixels", px4, 48'h0);
    check("rst_count", pc4, 16'h0);
    check("rst_end", pe4, 1'b0);
    check("rst_short", se4, 1'b0);
    rst_n_i = 1'b1;
    tick();

    // RAW10, 4 lanes, 5 beats: AA 55 FF 00 E4 10 20 30 40 00 01 02 03 04 FF 00..
    v4 = 1'b1; m4 = 2'b01; d4 = 32'h00FF55AA; tick();
    check("r10_b1_valid", pv4, 1'b0);
    m4 = 2'b00; d4 = 32'h302010E4; tick();
    check("r10_b2_valid", pv4, 1'b1);
    check("r10_g1_pixels", px4, 48'hAA0_554_FF8_00C);
    check("r10_b2_count", pc4, 16'd4);
    d4 = 32'h02010040; tick();
    check("r10_b3_valid", pv4, 1'b1);
    check("r10_g2_pixels", px4, 48'h100_200_300_400);
    d4 = 32'h00FF0403; tick();
    check("r10_b4_valid", pv4, 1'b1);
    check("r10_g3_pixels", px4, 48'h01C_02C_03C_04C);
    d4 = 32'h00000000; tick();
    check("r10_b5_valid", pv4, 1'b1);
    check("r10_b5_count", pc4, 16'd16);
    v4 = 1'b0; tick();
    check("r10_end", pe4, 1'b1);
    check("r10_short", se4, 1'b0);
    check("r10_idle_valid", pv4, 1'b0);
    check("r10_idle_pixels", px4, 48'h0);
    check("r10_hold_count", pc4, 16'd16);
    tick();
    check("r10_end_once", pe4, 1'b0);

    // RAW12, 4 lanes: 12 34 65 AB CD EF 00 00 (2 residual bytes).
    v4 = 1'b1; m4 = 2'b10; d4 = 32'hAB653412; tick();
    check("r12_b1_valid", pv4, 1'b0);
    check("r12_start_count", pc4, 16'd0);
    d4 = 32'h0000EFCD; tick();
    check("r12_b2_valid", pv4, 1'b1);
    check("r12_pixels", px4, 48'h125_346_ABF_CDE);
    v4 = 1'b0; tick();
    check("r12_end", pe4, 1'b1);
    check("r12_short", se4, 1'b1);
    check("r12_count", pc4, 16'd4);
    tick();

    // RAW8, 1 lane: bytes 01..08.
    v1 = 1'b1; m1 = 2'b00;
    for (int i = 1; i <= 8; i++) begin
      d1 = 8'(i);
      tick();
      if (i == 4) begin
        check("r8_g1_valid", pv1, 1'b1);
        check("r8_g1_pixels", px1, 48'h010_020_030_040);
      end else if (i == 8) begin
        check("r8_g2_valid", pv1, 1'b1);
        check("r8_g2_pixels", px1, 48'h050_060_070_080);
        check("r8_count", pc1, 16'd8);
      end else begin
        check("r8_gap_valid", pv1, 1'b0);
      end
    end
    v1 = 1'b0; tick();
    check("r8_end", pe1, 1'b1);
    check("r8_short", se1, 1'b0);
    tick();

    // Short payload: RAW10, 3 beats = 2 groups + 2 residual bytes.
    v4 = 1'b1; m4 = 2'b01; d4 = 32'h04030201; tick();
    check("sh_b1_valid", pv4, 1'b0);
    d4 = 32'h00000000; tick();
    check("sh_b2_valid", pv4, 1'b1);
    check("sh_g1_pixels", px4, 48'h010_020_030_040);
    d4 = 32'h00000000; tick();
    check("sh_b3_valid", pv4, 1'b1);
    check("sh_count", pc4, 16'd8);
    v4 = 1'b0; tick();
    check("sh_end", pe4, 1'b1);
    check("sh_short", se4, 1'b1);
    tick();

    // Mode toggles mid-packet (RAW12 sampled), then one idle cycle, then RAW8.
    v4 = 1'b1; m4 = 2'b10; d4 = 32'hAB653412; tick();
    check("mc_b1_valid", pv4, 1'b0);
    m4 = 2'b00; d4 = 32'h3412EFCD; tick();
    check("mc_b2_valid", pv4, 1'b1);
    check("mc_g1_pixels", px4, 48'h125_346_ABF_CDE);
    m4 = 2'b01; d4 = 32'hEFCDAB65; tick();
    check("mc_b3_valid", pv4, 1'b1);
    check("mc_g2_pixels", px4, 48'h125_346_ABF_CDE);
    check("mc_count", pc4, 16'd8);
    v4 = 1'b0; m4 = 2'b00; tick();
    check("mc_end", pe4, 1'b1);
    check("mc_short", se4, 1'b0);
    check("mc_idle_valid", pv4, 1'b0);
    v4 = 1'b1; d4 = 32'h44332211; tick();
    check("b2b_valid", pv4, 1'b1);
    check("b2b_pixels", px4, 48'h110_220_330_440);
    check("b2b_count", pc4, 16'd4);
    check("b2b_no_end", pe4, 1'b0);
    v4 = 1'b0; tick();
    check("b2b_end", pe4, 1'b1);
    tick();

    // Reset during beat 3 of a RAW10 packet.
    v4 = 1'b1; m4 = 2'b01; d4 = 32'h04030201; tick();
    d4 = 32'h00000000; tick();
    check("rm_b2_valid", pv4, 1'b1);
    d4 = 32'h11111111;
    #2 rst_n_i = 1'b0;
    #1;
    check("rm_async_valid", pv4, 1'b0);
    check("rm_async_pixels", px4, 48'h0);
    check("rm_async_count", pc4, 16'h0);
    tick();
    check("rm_no_end", pe4, 1'b0);
    rst_n_i = 1'b1;
    d4 = 32'h00FF55AA; tick();
    check("rm_n1_valid", pv4, 1'b0);
    check("rm_n1_no_end", pe4, 1'b0);
    d4 = 32'h302010E4; tick();
    check("rm_n2_valid", pv4, 1'b1);
    check("rm_n2_pixels", px4, 48'hAA0_554_FF8_00C);
    check("rm_n2_count", pc4, 16'd4);
    v4 = 1'b0; tick();
    check("rm_end", pe4, 1'b1);
    check("rm_short", se4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
